// File: rtl/joy_debounce_autofire_pkg.sv
// Shared types and constants for the joystick conditioning block.
package joy_debounce_autofire_pkg;
`include "joy_defines.vh"

    localparam int JOY_RIGHT = `JOY_RIGHT;
    localparam int JOY_LEFT  = `JOY_LEFT;
    localparam int JOY_DOWN  = `JOY_DOWN;
    localparam int JOY_UP    = `JOY_UP;
    localparam int JOY_FIRE  = `JOY_FIRE;
    localparam int JOY_FIRE2 = `JOY_FIRE2;

    // Bits that pass straight from the debouncer; fire is owned by the autofire FSM.
    localparam logic [5:0] FIRE_BIT  = 6'(1 << JOY_FIRE);
    localparam logic [5:0] PASS_MASK = 6'((1 << JOY_RIGHT) | (1 << JOY_LEFT) | (1 << JOY_DOWN)
                                          | (1 << JOY_UP) | (1 << JOY_FIRE2));

    typedef enum logic [1:0] {
        AF_IDLE     = 2'd0,
        AF_FIRE_ON  = 2'd1,
        AF_FIRE_OFF = 2'd2
    } af_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/joy_debounce_bit.sv
// One joystick line: two-flop synchroniser followed by a tick-counted debouncer.
module joy_debounce_bit
    import joy_debounce_autofire_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic s
);
    localparam int CW = cnt_width(DEBOUNCE_TICKS + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          s_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            s_reg     <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            // Any return to the accepted level discards the partial count.
            if (sync2_reg == s_reg) begin
                cnt_reg <= '0;
            end else if (tick) begin
                if (cnt_reg == CW'(DEBOUNCE_TICKS - 1)) begin
                    s_reg   <= sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    end

    assign s = s_reg;
endmodule

// File: rtl/joy_defines.vh
// Bit positions of the joystick lines within each 6-bit port word.
`ifndef JOY_DEFINES_VH
`define JOY_DEFINES_VH
`define JOY_RIGHT 0
`define JOY_LEFT  1
`define JOY_DOWN  2
`define JOY_UP    3
`define JOY_FIRE  4
`define JOY_FIRE2 5
`endif

// File: rtl/joy_debounce_autofire.sv
// Debounces both joystick ports, adds optional autofire on fire, and flags output changes.
module joy_debounce_autofire
    import joy_debounce_autofire_pkg::*;
#(
    parameter int TICK_DIV            = 28375,
    parameter int DEBOUNCE_TICKS      = 5,
    parameter int AUTOFIRE_HALF_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] joya_in,
    input  logic [5:0] joyb_in,
    input  logic [1:0] autofire_en,
    output logic [5:0] joya_out,
    output logic [5:0] joyb_out,
    output logic       changed
);
    localparam int PW = cnt_width(TICK_DIV);
    localparam int HW = cnt_width(AUTOFIRE_HALF_TICKS);

    logic [PW-1:0] pcnt_reg;
    logic          tick;
    logic [11:0]   raw;
    logic [11:0]   s;
    logic [11:0]   out_next;
    logic [11:0]   out_reg;
    logic          changed_reg;

    assign tick = (pcnt_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg <= '0;
        end else if (tick) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + PW'(1);
        end
    end

    assign raw = {joyb_in, joya_in};

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_bit
            joy_debounce_bit #(
                .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
            ) u_bit (
                .clk (clk),
                .rst (rst),
                .tick(tick),
                .raw (raw[gi]),
                .s   (s[gi])
            );
        end

        for (gi = 0; gi < 2; gi++) begin : g_port
            af_state_t     state_reg;
            af_state_t     state_next;
            logic [HW-1:0] half_reg;
            logic [HW-1:0] half_next;
            logic          s_fire;
            logic          fire_level;
            logic          expire;

            assign s_fire = s[gi*6 + JOY_FIRE];
            assign expire = tick && (half_reg == HW'(AUTOFIRE_HALF_TICKS - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= AF_IDLE;
                    half_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    half_reg  <= half_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                half_next  = half_reg;
                fire_level = s_fire;
                case (state_reg)
                    AF_IDLE: begin
                        if (autofire_en[gi] && !s_fire) begin
                            state_next = AF_FIRE_ON;
                            half_next  = '0;
                        end
                    end
                    AF_FIRE_ON, AF_FIRE_OFF: begin
                        fire_level = (state_reg == AF_FIRE_OFF);
                        // Leaving autofire wins over a half-period expiry in the same cycle.
                        if (s_fire || !autofire_en[gi]) begin
                            state_next = AF_IDLE;
                            half_next  = '0;
                        end else if (expire) begin
                            state_next = (state_reg == AF_FIRE_ON) ? AF_FIRE_OFF : AF_FIRE_ON;
                            half_next  = '0;
                        end else if (tick) begin
                            half_next = half_reg + HW'(1);
                        end
                    end
                    default: begin
                        state_next = AF_IDLE;
                        half_next  = '0;
                    end
                endcase
            end

            assign out_next[gi*6 +: 6] = (s[gi*6 +: 6] & PASS_MASK) | (fire_level ? FIRE_BIT : 6'h00);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg     <= 12'hFFF;
            changed_reg <= 1'b0;
        end else begin
            out_reg     <= out_next;
            changed_reg <= (out_next != out_reg);
        end
    end

    assign joya_out = out_reg[5:0];
    assign joyb_out = out_reg[11:6];
    assign changed  = changed_reg;
endmodule

// File: tb/tb_joy_debounce_autofire.sv
// Directed scenarios plus randomized joystick traffic checked cycle by cycle against a reference model.
module tb_joy_debounce_autofire;
    localparam int TD = 4;
    localparam int DT = 3;
    localparam int AH = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] joya_in;
    logic [5:0] joyb_in;
    logic [1:0] autofire_en;
    logic [5:0] joya_out;
    logic [5:0] joyb_out;
    logic       changed;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    joy_debounce_autofire #(
        .TICK_DIV(TD),
        .DEBOUNCE_TICKS(DT),
        .AUTOFIRE_HALF_TICKS(AH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .joya_in(joya_in),
        .joyb_in(joyb_in),
        .autofire_en(autofire_en),
        .joya_out(joya_out),
        .joyb_out(joyb_out),
        .changed(changed)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a line is accepted once its new level has been seen on DT
    // millisecond ticks in a row, two clocks after it arrives; autofire is a phase
    // (0 = follow fire, 1 = forced low, 2 = forced high) with a tick count.
    logic [11:0] m_hist[$];
    logic [11:0] m_s;
    logic [11:0] m_out;
    logic        m_changed;
    int          m_persist[12];
    int          m_phase[2];
    int          m_ticks[2];
    int          m_cycle;

    task automatic model_reset();
        m_hist    = '{12'hFFF, 12'hFFF};
        m_s       = 12'hFFF;
        m_out     = 12'hFFF;
        m_changed = 1'b0;
        m_cycle   = 0;
        for (int b = 0; b < 12; b++) m_persist[b] = 0;
        for (int p = 0; p < 2; p++) begin
            m_phase[p] = 0;
            m_ticks[p] = 0;
        end
    endtask

    task automatic model_step();
        logic [11:0] seen;
        logic [11:0] s_new;
        logic [11:0] out_new;
        bit          tk;
        tk      = (m_cycle % TD) == (TD - 1);
        seen    = m_hist[0];
        s_new   = m_s;
        out_new = m_s;
        for (int p = 0; p < 2; p++) begin
            int fb;
            fb = p * 6 + 4;
            out_new[fb] = (m_phase[p] == 0) ? m_s[fb] : (m_phase[p] == 2);
        end
        m_changed = (out_new != m_out);
        m_out     = out_new;
        for (int b = 0; b < 12; b++) begin
            if (seen[b] == m_s[b]) m_persist[b] = 0;
            else if (tk) begin
                m_persist[b]++;
                if (m_persist[b] == DT) begin
                    s_new[b]     = seen[b];
                    m_persist[b] = 0;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            logic sf;
            sf = m_s[p * 6 + 4];
            if (m_phase[p] == 0) begin
                if (autofire_en[p] && !sf) begin
                    m_phase[p] = 1;
                    m_ticks[p] = 0;
                end
            end else if (sf || !autofire_en[p]) begin
                m_phase[p] = 0;
                m_ticks[p] = 0;
            end else if (tk) begin
                m_ticks[p]++;
                if (m_ticks[p] == AH) begin
                    m_phase[p] = 3 - m_phase[p];
                    m_ticks[p] = 0;
                end
            end
        end
        m_s = s_new;
        m_hist.push_back({joyb_in, joya_in});
        void'(m_hist.pop_front());
        m_cycle++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        check("cyc_joya", 32'(joya_out), 32'(m_out[5:0]));
        check("cyc_joyb", 32'(joyb_out), 32'(m_out[11:6]));
        check("cyc_changed", 32'(changed), 32'(m_changed));
    end

    task automatic step_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fire(input logic lvl, output bit ok);
        logic prev;
        prev = joya_out[4];
        ok   = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step_sample();
            if (joya_out[4] == lvl && prev != lvl) ok = 1'b1;
            prev = joya_out[4];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int   fall_k, nchg, nbad, tog_n;
        int   tog[$];
        bit   ok;
        logic prev;
        logic [11:0] prev12;

        model_reset();
        rst = 1'b1;
        joya_in = 6'h3F;
        joyb_in = 6'h3F;
        autofire_en = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_joya", 32'(joya_out), 32'h3F);
        check("reset_joyb", 32'(joyb_out), 32'h3F);
        check("reset_changed", 32'(changed), 32'h0);
        rst = 1'b0;
        $display("[TB] reset released");

        // Asynchronous reset while fire is debounced low.
        @(negedge clk) joya_in[4] = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_joya", 32'(joya_out), 32'h2F);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_joya", 32'(joya_out), 32'h3F);
        check("async_rst_joyb", 32'(joyb_out), 32'h3F);
        check("async_rst_changed", 32'(changed), 32'h0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        nbad = 0;
        repeat (10) begin
            @(negedge clk);
            if (joya_out !== 6'h3F || changed !== 1'b0) nbad++;
        end
        check("hold_after_rst", 32'(nbad), 32'h0);
        repeat (10) @(negedge clk);
        check("redebounce_joya", 32'(joya_out), 32'h2F);
        joya_in[4] = 1'b1;
        repeat (25) @(negedge clk);
        $display("[TB] async reset scenario done, joya_out=%h", joya_out);

        // Press latency on port A up.
        @(negedge clk) joya_in[3] = 1'b0;
        fall_k = -1;
        nchg = 0;
        for (int k = 0; k < 30; k++) begin
            step_sample();
            if (changed) nchg++;
            if (fall_k < 0 && joya_out[3] == 1'b0) fall_k = k;
        end
        check("lat_window", 32'(fall_k >= 11 && fall_k <= 14), 32'h1);
        check("lat_changed_pulses", 32'(nchg), 32'h1);
        check("lat_joyb_steady", 32'(joyb_out), 32'h3F);
        $display("[TB] press latency %0d cycles, changed pulses %0d", fall_k, nchg);

        // Two-tick glitch on port B right is rejected.
        @(negedge clk) joyb_in[0] = 1'b0;
        nchg = 0;
        nbad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 7) joyb_in[0] = 1'b1;
            if (changed) nchg++;
            if (joyb_out[0] !== 1'b1) nbad++;
        end
        check("glitch_joyb0", 32'(nbad), 32'h0);
        check("glitch_changed", 32'(nchg), 32'h0);
        $display("[TB] glitch scenario: changed pulses %0d", nchg);

        // Autofire on port A.
        @(negedge clk);
        autofire_en = 2'b01;
        joya_in[4] = 1'b0;
        prev = joya_out[4];
        nbad = 0;
        tog.delete();
        for (int k = 0; k < 160; k++) begin
            step_sample();
            if (joya_out[4] != prev) begin
                tog.push_back(k);
                check("af_changed_at_toggle", 32'(changed), 32'h1);
                prev = joya_out[4];
            end
            if (joya_out[5] !== 1'b1) nbad++;
        end
        check("af_fire2_steady", 32'(nbad), 32'h0);
        check("af_enough_toggles", 32'(tog.size() >= 5), 32'h1);
        for (int i = 1; i + 1 < tog.size(); i++)
            check("af_half_period", 32'(tog[i+1] - tog[i]), 32'd20);
        $display("[TB] autofire scenario: %0d toggles", tog.size());

        // Release fire while the autofire output is high.
        wait_fire(1'b1, ok);
        check("rel_rise_seen", 32'(ok), 32'h1);
        joya_in[4] = 1'b1;
        prev = joya_out[4];
        tog_n = 0;
        for (int k = 0; k < 45; k++) begin
            step_sample();
            if (joya_out[4] != prev) tog_n++;
            prev = joya_out[4];
        end
        check("rel_no_toggle", 32'(tog_n), 32'h0);
        check("rel_fire_level", 32'(joya_out[4]), 32'h1);

        // Drop autofire_en while the autofire output is low.
        joya_in[4] = 1'b0;
        wait_fire(1'b1, ok);
        check("dis_rise_seen", 32'(ok), 32'h1);
        wait_fire(1'b0, ok);
        check("dis_fall_seen", 32'(ok), 32'h1);
        repeat (3) step_sample();
        autofire_en = 2'b00;
        prev = joya_out[4];
        tog_n = 0;
        for (int k = 0; k < 45; k++) begin
            step_sample();
            if (joya_out[4] != prev) tog_n++;
            prev = joya_out[4];
        end
        check("dis_no_toggle", 32'(tog_n), 32'h0);
        check("dis_fire_level", 32'(joya_out[4]), 32'h0);
        $display("[TB] autofire exit scenarios done");

        // All twelve lines pressed together.
        @(negedge clk);
        joya_in = 6'h3F;
        joyb_in = 6'h3F;
        repeat (30) @(negedge clk);
        joya_in = 6'h00;
        joyb_in = 6'h00;
        prev12 = {joyb_out, joya_out};
        nchg = 0;
        tog_n = 0;
        for (int k = 0; k < 30; k++) begin
            step_sample();
            if ({joyb_out, joya_out} != prev12) tog_n++;
            if (changed) nchg++;
            prev12 = {joyb_out, joya_out};
        end
        check("all_one_step", 32'(tog_n), 32'h1);
        check("all_changed_pulses", 32'(nchg), 32'h1);
        check("all_joya", 32'(joya_out), 32'h0);
        check("all_joyb", 32'(joyb_out), 32'h0);
        $display("[TB] simultaneous press: %0d output steps, %0d pulses", tog_n, nchg);

        // Randomized traffic with occasional asynchronous resets.
        for (int it = 0; it < 80; it++) begin
            logic [11:0] flip;
            int hold;
            @(negedge clk);
            flip = '0;
            for (int b = 0; b < 12; b++) flip[b] = ($urandom_range(0, 3) == 0);
            joya_in = joya_in ^ flip[5:0];
            joyb_in = joyb_in ^ flip[11:6];
            if ($urandom_range(0, 3) == 0) autofire_en = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 40);
            if ($urandom_range(0, 9) == 0) begin
                #($urandom_range(1, 4));
                rst = 1'b1;
                @(negedge clk) rst = 1'b0;
            end
            repeat (hold) @(negedge clk);
            $display("[TB] random %0d: joya_in=%h joyb_in=%h en=%b joya_out=%h joyb_out=%h",
                     it, joya_in, joyb_in, autofire_en, joya_out, joyb_out);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/joy_debounce_autofire.md
Name: joy_debounce_autofire

Overview:
Conditions the raw joystick lines from the SPI port-expander reader before they reach the Minimig core's JOYA/JOYB inputs, in the clk_28 domain.
- Synchronises each of the 12 lines and debounces it against a millisecond tick.
- Optionally generates autofire on the fire button per port.
- Emits a change strobe.

Parameters:
TICK_DIV, 28375, clk cycles per debounce/autofire tick (1 kHz at 28.375 MHz)
DEBOUNCE_TICKS, 5, consecutive ticks a new level must persist before acceptance
AUTOFIRE_HALF_TICKS, 50, ticks per autofire half-period (10 Hz at defaults)

Ports:
clk  in  1  clock (clk_28 domain)
rst  in  1  asynchronous reset, active-high
joya_in  in  6  port A raw, active-low: [5]fire2 [4]fire [3]up [2]down [1]left [0]right
joyb_in  in  6  port B raw, same bit map
autofire_en  in  2  [0] port A, [1] port B; level, synchronous to clk
joya_out  out  6  port A conditioned, active-low
joyb_out  out  6  port B conditioned, active-low
changed  out  1  one-cycle strobe when any output bit differs from its previous-cycle value

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. Every register clears on rst assertion regardless of clk.
- Reset values:
  - joya_out = joyb_out = 6'h3F (released); changed = 0.
  - Sync flops = 1; debounced state = 1.
  - Debounce counters, prescaler and autofire counters = 0; autofire FSMs in IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the cycle the count equals TICK_DIV-1.
  - Width is clog2(TICK_DIV).
- Synchroniser: two-flop per input bit; autofire_en is not synchronised.
- Debounce, per bit, with state s and counter c (width clog2(DEBOUNCE_TICKS+1)):
  - Sync level == s: c <= 0 on every cycle, tick or not.
  - Sync level != s and tick: c <= c+1.
  - When c+1 == DEBOUNCE_TICKS on a tick: s <= sync level and c <= 0 in the same cycle.
  - A glitch shorter than DEBOUNCE_TICKS ticks never changes s.
  - Latency from a raw edge to s, for a steady input: min 2+(DEBOUNCE_TICKS-1)*TICK_DIV+1 cycles, max 2+DEBOUNCE_TICKS*TICK_DIV cycles.
- Output mapping:
  - Bits [5] and [3:0] of each port are s, registered by one cycle.
  - Bit [4] comes from the autofire FSM.
- Autofire FSM, per port p, states IDLE, FIRE_ON, FIRE_OFF; half counter h:
  - IDLE: fire out = s_fire.
    - If autofire_en[p]=1 and s_fire=0: go to FIRE_ON, h <= 0.
  - FIRE_ON: fire out = 0. On tick h <= h+1. On the tick where h+1 == AUTOFIRE_HALF_TICKS: go to FIRE_OFF, h <= 0.
  - FIRE_OFF: fire out = 1. Same counting. On expiry go to FIRE_ON.
  - From FIRE_ON or FIRE_OFF: s_fire=1 or autofire_en[p]=0 forces IDLE on the next cycle. This takes priority over expiry in the same cycle. Fire out then follows s_fire.
  - Enabling autofire while fire is already held enters FIRE_ON on the next cycle.
- changed:
  - Registered compare of {joya_out, joyb_out} with its value one cycle earlier.
  - Asserted for one cycle per differing update; 0 during and for the first cycle after reset.
- Mid-operation reset: outputs return to 6'h3F immediately (asynchronously). Debouncing restarts from the released state.
- Ports A and B are fully independent; simultaneous events on both resolve in the same cycle.

Decomposition:
- joy_defines.vh holds the bit-index constants: JOY_RIGHT=0, JOY_LEFT=1, JOY_DOWN=2, JOY_UP=3, JOY_FIRE=4, JOY_FIRE2=5.
- Sub-module joy_debounce_bit, 12 instances:
  - Contains the two-flop synchroniser, the counter and state s.
  - Inputs: clk, rst, tick, raw. Output: s.
  - Parameter: DEBOUNCE_TICKS.
- The prescaler, both autofire FSMs, output registers and changed logic stay in the top module.

Test Plan:
Sim parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, AUTOFIRE_HALF_TICKS=5.
1. Assert rst mid-run with joya_out=6'h2F, asynchronously and without a clk edge -> joya_out=joyb_out=6'h3F and changed=0 immediately; they hold after release until the inputs are debounced.
2. Drive joya_in[3] to 0 and hold -> joya_out[3] falls no earlier than 11 and no later than 14 cycles after the edge; changed pulses for exactly one cycle; joyb_out unchanged.
3. Drive joyb_in[0] low for 2 ticks (8 cycles), then return it high -> joyb_out[0] stays 1 throughout; changed never asserts.
4. Set autofire_en=2'b01 and hold joya_in[4]=0 -> after debounce, joya_out[4] alternates 0 for 20 cycles and 1 for 20 cycles; changed pulses at every toggle; joya_out[5] is unaffected.
5. Release fire during FIRE_OFF, then separately drop autofire_en during FIRE_ON -> the FSM returns to IDLE one cycle later, and joya_out[4] tracks the debounced fire level with no extra toggle.
6. Debounce press edges on all 12 bits in the same tick -> all output bits change in one cycle, and changed is a single one-cycle pulse.
